// File: rtl/tt_stim_if.sv
// tt_stim_if
//   Bus between the stimulus sequencer/checker and the block under test.
//   master : the sequencer. It takes start and y, and drives the stimulus
//            and result outputs.
//   slave  : the environment side. It drives start and y, and observes the
//            stimulus and result outputs.
//   Signals:
//     start      1-cycle pulse that begins a sweep
//     a, b, c    stimulus vector bits 2, 1, 0
//     y          response of the combinational block under test
//     vec_idx    index of the vector currently driven
//     busy, done sweep status
//     pass, err_count, fail_idx, fail_seen   sweep results
interface tt_stim_if;
  logic       start;
  logic       a;
  logic       b;
  logic       c;
  logic       y;
  logic [2:0] vec_idx;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [2:0] fail_idx;
  logic       fail_seen;

  modport master (
    input  start, y,
    output a, b, c, vec_idx, busy, done, pass, err_count, fail_idx, fail_seen
  );

  modport slave (
    output start, y,
    input  a, b, c, vec_idx, busy, done, pass, err_count, fail_idx, fail_seen
  );
endinterface

// File: rtl/tt_stim_checker.sv
// tt_stim_checker
//   Stimulus sequencer and self-checker for a 3-input combinational block.
//   When started, it walks {a,b,c} through 000..111 and holds each vector
//   for HOLD_CYCLES clocks. On the last clock of each hold it samples y and
//   compares it with EXPECTED[vector]. At the end of the sweep it reports:
//     - pass
//     - the mismatch count
//     - the first failing vector
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    tt_stim_if.master: start and y in; stimulus and results out
//   Parameters:
//     HOLD_CYCLES  clocks each vector is held (2..255)
//     EXPECTED     bit i is the expected y for {a,b,c} == i
module tt_stim_checker #(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter logic [7:0]  EXPECTED    = 8'b1110_1000
) (
  input  logic clk,
  input  logic rst_n,
  tt_stim_if.master bus
);

  localparam logic [7:0] LAST_HOLD = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] vec_idx_q, vec_idx_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] err_count_q, err_count_d;
  logic [2:0] fail_idx_q, fail_idx_d;
  logic       fail_seen_q, fail_seen_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       mismatch_s;

  // X/Z on y must count as a mismatch, hence the case inequality.
  assign mismatch_s = (bus.y !== EXPECTED[vec_idx_q]);

  // Next-state and next-output logic for the sweep FSM.
  always_comb begin
    state_d     = state_q;
    vec_idx_d   = vec_idx_q;
    hold_cnt_d  = hold_cnt_q;
    err_count_d = err_count_q;
    fail_idx_d  = fail_idx_q;
    fail_seen_d = fail_seen_q;
    pass_d      = pass_q;
    busy_d      = busy_q;
    done_d      = done_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_DRIVE;
          vec_idx_d   = 3'd0;
          hold_cnt_d  = 8'd0;
          err_count_d = 4'd0;
          fail_idx_d  = 3'd0;
          fail_seen_d = 1'b0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DRIVE: begin
        // start is deliberately ignored here: a sweep is never restarted.
        busy_d     = 1'b1;
        hold_cnt_d = hold_cnt_q + 8'd1;
        if (hold_cnt_q == LAST_HOLD) begin
          if (mismatch_s) begin
            // At most 8 samples per sweep, so 4 bits never wrap.
            err_count_d = err_count_q + 4'd1;
            if (!fail_seen_q) begin
              fail_idx_d  = vec_idx_q;
              fail_seen_d = 1'b1;
            end else begin
              fail_seen_d = 1'b1;
            end
          end else begin
            err_count_d = err_count_q;
          end
          if (vec_idx_q == 3'd7) begin
            // Last vector sampled: vec_idx and a,b,c freeze at 7.
            state_d    = ST_DONE;
            hold_cnt_d = 8'd0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            pass_d     = (err_count_d == 4'd0);
          end else begin
            vec_idx_d  = vec_idx_q + 3'd1;
            hold_cnt_d = 8'd0;
          end
        end else begin
          state_d = ST_DRIVE;
        end
      end

      ST_DONE: begin
        if (bus.start) begin
          state_d     = ST_DRIVE;
          vec_idx_d   = 3'd0;
          hold_cnt_d  = 8'd0;
          err_count_d = 4'd0;
          fail_idx_d  = 3'd0;
          fail_seen_d = 1'b0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
        end else begin
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      vec_idx_q   <= 3'd0;
      hold_cnt_q  <= 8'd0;
      err_count_q <= 4'd0;
      fail_idx_q  <= 3'd0;
      fail_seen_q <= 1'b0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_idx_q   <= vec_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      err_count_q <= err_count_d;
      fail_idx_q  <= fail_idx_d;
      fail_seen_q <= fail_seen_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // The stimulus is simply the registered vector index.
  assign bus.a         = vec_idx_q[2];
  assign bus.b         = vec_idx_q[1];
  assign bus.c         = vec_idx_q[0];
  assign bus.vec_idx   = vec_idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_count_q;
  assign bus.fail_idx  = fail_idx_q;
  assign bus.fail_seen = fail_seen_q;

endmodule
